prom_access_arb: RTL and testbench



---
 rtl/prom_access_arb_pkg.sv | 16 +
 rtl/prom_access_arb_if.sv | 26 ++
 rtl/prom_access_arb_arbpick2.sv | 17 +
 rtl/prom_access_arb.sv | 118 +++++++++++
 tb/tb_prom_access_arb.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/prom_access_arb_pkg.sv
// prom_access_arb_pkg: shared state encodings, WAIT legal range and port indices for the PROM arbiter.
package prom_access_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

endpackage

// File: rtl/prom_access_arb_if.sv
// prom_access_arb_if: requester-side bus of the PROM arbiter (two read ports plus shared read data).
interface prom_access_arb_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          vld0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          vld1;
    logic [DW-1:0] rdata;
    logic          busy;

    modport master (
        output req0, addr0, req1, addr1,
        input  gnt0, vld0, gnt1, vld1, rdata, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1,
        output gnt0, vld0, gnt1, vld1, rdata, busy
    );
endinterface

// File: rtl/prom_access_arb_arbpick2.sv
// prom_access_arb_arbpick2: combinational two-way picker, fixed priority (port 0) or round-robin against 'last'.
module prom_access_arb_arbpick2
    import prom_access_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic rr,
    output logic win,
    output logic any
);
    // a lone request always wins; a tie goes to port 0, or to the port not granted last in round-robin
    always_comb begin
        any = req0 | req1;
        win = (req0 & req1) ? (rr ? ~last : P0) : req1;
    end
endmodule

// File: rtl/prom_access_arb.sv
// prom_access_arb: two-port read arbiter/sequencer for an async-read PROM; PROM_RR_EN selects round-robin arbitration.
module prom_access_arb
    import prom_access_arb_pkg::*;
#(
    parameter int AW   = 5,
    parameter int DW   = 8,
    parameter int WAIT = 2
) (
    input  logic          clk,
    input  logic          rst_,
    prom_access_arb_if.slave bus,
    output logic [AW-1:0] rom_a,
    output logic          rom_cs_,
    input  logic [DW-1:0] rom_q
);
    localparam logic [3:0] WAIT_M1 = 4'(WAIT - 1);

    if (WAIT < WAIT_MIN || WAIT > WAIT_MAX) begin : g_wait_bad
        $error("prom_access_arb: WAIT=%0d outside %0d..%0d", WAIT, WAIT_MIN, WAIT_MAX);
    end

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          owner, owner_nxt;
    logic [AW-1:0] rom_a_nxt;
    logic          rom_cs_nxt;
    logic [DW-1:0] rdata_nxt;
    logic          gnt0_nxt, gnt1_nxt, vld0_nxt, vld1_nxt;
    logic          win, any, last, rr;

`ifdef PROM_RR_EN
    assign rr = 1'b1;
    // remember the most recently granted port; port 1 after reset so port 0 goes first
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            last <= P1;
        else if (state == S_IDLE && any)
            last <= win;
    end
`else
    assign rr   = 1'b0;
    assign last = P1;
`endif

    prom_access_arb_arbpick2 u_pick (
        .req0 (bus.req0),
        .req1 (bus.req1),
        .last (last),
        .rr   (rr),
        .win  (win),
        .any  (any)
    );

    // next state plus next value of every registered output
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        owner_nxt  = owner;
        rom_a_nxt  = rom_a;
        rom_cs_nxt = 1'b1;
        rdata_nxt  = bus.rdata;
        gnt0_nxt   = 1'b0;
        gnt1_nxt   = 1'b0;
        vld0_nxt   = 1'b0;
        vld1_nxt   = 1'b0;
        case (state)
            S_IDLE: if (any) begin
                state_nxt  = S_ACCESS;
                cnt_nxt    = WAIT_M1;
                owner_nxt  = win;
                rom_a_nxt  = win ? bus.addr1 : bus.addr0;
                rom_cs_nxt = 1'b0;
                gnt0_nxt   = ~win;
                gnt1_nxt   = win;
            end
            S_ACCESS: if (cnt != 4'd0) begin
                cnt_nxt    = cnt - 4'd1;
                rom_cs_nxt = 1'b0;
            end else begin
                state_nxt  = S_DONE;
                rdata_nxt  = rom_q;
                vld0_nxt   = ~owner;
                vld1_nxt   = owner;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // all state and outputs registered; reset forces chip select high immediately
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            owner     <= P0;
            rom_a     <= '0;
            rom_cs_   <= 1'b1;
            bus.rdata <= '0;
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.vld0  <= 1'b0;
            bus.vld1  <= 1'b0;
            bus.busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            owner     <= owner_nxt;
            rom_a     <= rom_a_nxt;
            rom_cs_   <= rom_cs_nxt;
            bus.rdata <= rdata_nxt;
            bus.gnt0  <= gnt0_nxt;
            bus.gnt1  <= gnt1_nxt;
            bus.vld0  <= vld0_nxt;
            bus.vld1  <= vld1_nxt;
            bus.busy  <= state_nxt != S_IDLE;
        end
    end
endmodule

// File: tb/tb_prom_access_arb.sv
// tb_prom_access_arb: directed bench for prom_access_arb with behavioural PROMs (mem[i] = i ^ 8'hA5).
module tb_prom_access_arb;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prom_access_arb_if #(.AW(5), .DW(8)) if2 ();
    prom_access_arb_if #(.AW(5), .DW(8)) if15 ();

    logic [4:0] rom_a2, rom_a15;
    logic       rom_cs2, rom_cs15;
    logic [7:0] rom_q2, rom_q15;

    assign rom_q2  = rom_cs2  ? 8'hFF : ({3'b000, rom_a2}  ^ 8'hA5);
    assign rom_q15 = rom_cs15 ? 8'hFF : ({3'b000, rom_a15} ^ 8'hA5);

    prom_access_arb #(.AW(5), .DW(8), .WAIT(2)) dut2 (
        .clk     (clk),
        .rst_    (rst_),
        .bus     (if2),
        .rom_a   (rom_a2),
        .rom_cs_ (rom_cs2),
        .rom_q   (rom_q2)
    );

    prom_access_arb #(.AW(5), .DW(8), .WAIT(15)) dut15 (
        .clk     (clk),
        .rst_    (rst_),
        .bus     (if15),
        .rom_a   (rom_a15),
        .rom_cs_ (rom_cs15),
        .rom_q   (rom_q15)
    );

    wire [5:0] flags2 = {if2.gnt0, if2.gnt1, if2.vld0, if2.vld1, if2.busy, rom_cs2};

`ifdef PROM_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    initial begin
        int low;
        int vc;
        logic w;
        {if2.req0, if2.req1, if2.addr0, if2.addr1} = '0;
        {if15.req0, if15.req1, if15.addr0, if15.addr1} = '0;
        repeat (3) @(negedge clk);
        chk("rst_flags", 32'(flags2), 32'b000001);
        chk("rst_rom_a", 32'(rom_a2), 32'h0);
        chk("rst_rdata", 32'(if2.rdata), 32'h0);
        rst_ = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_flags", 32'(flags2), 32'b000001);
        end
        if2.addr0 = 5'h03;
        if2.req0 = 1'b1;
        @(negedge clk);
        chk("t2_c1", 32'(flags2), 32'b100010);
        chk("t2_rom_a", 32'(rom_a2), 32'h03);
        if2.req0 = 1'b0;
        @(negedge clk);
        chk("t2_c2", 32'(flags2), 32'b000010);
        @(negedge clk);
        chk("t2_c3", 32'(flags2), 32'b001011);
        chk("t2_rdata", 32'(if2.rdata), 32'hA6);
        @(negedge clk);
        chk("t2_c4", 32'(flags2), 32'b000001);
        chk("t2_hold", 32'(if2.rdata), 32'hA6);
        rst_ = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        if2.addr0 = 5'h00;
        if2.addr1 = 5'h1F;
        if2.req0 = 1'b1;
        if2.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = RR ? k[0] : 1'b0;
            @(negedge clk);
            chk("t3_gnt", 32'({if2.gnt0, if2.gnt1}), w ? 32'b01 : 32'b10);
            repeat (2) @(negedge clk);
            chk("t3_vld", 32'({if2.vld0, if2.vld1}), w ? 32'b01 : 32'b10);
            chk("t3_rdata", 32'(if2.rdata), w ? 32'hBA : 32'hA5);
            @(negedge clk);
            if (k == 3) begin
                if2.req0 = 1'b0;
                if2.req1 = 1'b0;
            end
        end
        if2.addr1 = 5'h10;
        if2.req1 = 1'b1;
        @(negedge clk);
        chk("t4_gnt", 32'(flags2), 32'b010010);
        if2.req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_vld", 32'(flags2), 32'b000111);
        chk("t4_rdata", 32'(if2.rdata), 32'hB5);
        @(negedge clk);
        chk("t4_idle", 32'(flags2), 32'b000001);
        if2.addr0 = 5'h03;
        if2.req0 = 1'b1;
        @(negedge clk);
        chk("t5_gnt", 32'(flags2), 32'b100010);
        @(negedge clk);
        chk("t5_cs_low", 32'(rom_cs2), 32'h0);
        #2;
        rst_ = 1'b0;
        if2.req0 = 1'b0;
        #1;
        chk("t5_async", 32'(flags2), 32'b000001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_in_rst", 32'(flags2), 32'b000001);
        end
        rst_ = 1'b1;
        @(negedge clk);
        chk("t5_after", 32'(flags2), 32'b000001);
        if2.addr0 = 5'h07;
        if2.req0 = 1'b1;
        @(negedge clk);
        chk("t5_regnt", 32'(flags2), 32'b100010);
        chk("t5_rom_a", 32'(rom_a2), 32'h07);
        if2.req0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_vld", 32'(flags2), 32'b001011);
        chk("t5_rdata", 32'(if2.rdata), 32'hA2);
        low = 0;
        vc = -1;
        if15.addr0 = 5'h1F;
        if15.req0 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("t6_gnt", 32'(if15.gnt0), 32'h1);
                if15.req0 = 1'b0;
            end
            if (!rom_cs15) low++;
            if (if15.vld0) vc = c;
        end
        chk("t6_cs_low", 32'(low), 32'd15);
        chk("t6_vld_cyc", 32'(vc), 32'd16);
        chk("t6_rdata", 32'(if15.rdata), 32'hBA);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
